// File: rtl/seq_shift_right_if.sv
// Handshake and operand bus for the multi-cycle right shifter.
// The requester drives start and the operands; the shifter returns busy, done and the result.
interface seq_shift_right_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
);

  logic               start;
  logic [DATA_W-1:0]  data_1;
  logic [SHAMT_W-1:0] data_2;
  logic               arith;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  out;

  modport master (
    output start,
    output data_1,
    output data_2,
    output arith,
    input  busy,
    input  done,
    input  out
  );

  modport slave (
    input  start,
    input  data_1,
    input  data_2,
    input  arith,
    output busy,
    output done,
    output out
  );

endinterface

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic,
// with a start/busy/done handshake and a result register held between operations.
module seq_shift_right #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  seq_shift_right_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [DATA_W-1:0]  wreg;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  shifted;

  assign shifted = {fill, wreg[DATA_W-1:1]};

  // A zero shift amount goes straight to DONE, so SHIFT always starts with a nonzero count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wreg   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            wreg <= bus.data_1;
            cnt  <= bus.data_2;
            fill <= bus.arith & bus.data_1[DATA_W-1];
            if (bus.data_2 == '0) begin
              result <= bus.data_1;
              state  <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          wreg <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result <= shifted;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == SHIFT) || (state == DONE);
  assign bus.done = (state == DONE);
  assign bus.out  = result;

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed testbench for seq_shift_right: hand-computed results, latencies,
// busy-ignore behaviour and asynchronous reset abort.
module tb_seq_shift_right;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_shift_right_if #(.DATA_W(8), .SHAMT_W(3)) bus ();

  seq_shift_right #(.DATA_W(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Present an operation, release start after the accepting edge, scramble the operands,
  // then wait (bounded) for done; cycles counts edges from the accepting edge to done.
  task automatic applyStimulus(input logic [7:0] d1, input logic [2:0] d2, input logic ar,
                               output int cycles, output logic [7:0] res);
    bus.start  = 1'b1;
    bus.data_1 = d1;
    bus.data_2 = d2;
    bus.arith  = ar;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.data_1 = ~d1;
    bus.data_2 = ~d2;
    bus.arith  = ~ar;
    cycles = 1;
    while (!bus.done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    res = bus.out;
  endtask

  task automatic runOp(input string tag, input logic [7:0] d1, input logic [2:0] d2,
                       input logic ar, input logic [7:0] expected);
    int         cycles;
    logic [7:0] res;
    applyStimulus(d1, d2, ar, cycles, res);
    checkOutput({tag, "_latency"}, cycles, d2 + 1);
    checkOutput({tag, "_out"}, res, expected);
    @(posedge clk); #1;
    checkOutput({tag, "_busy_after"}, bus.busy, 1'b0);
    checkOutput({tag, "_done_pulse"}, bus.done, 1'b0);
    checkOutput({tag, "_out_held"}, bus.out, expected);
  endtask

  initial begin
    int         cycles;
    logic [7:0] res;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.data_1 = 8'h00;
    bus.data_2 = 3'd0;
    bus.arith  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_done", bus.done, 1'b0);
    checkOutput("reset_out", bus.out, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    runOp("lsr_b4_3", 8'hB4, 3'd3, 1'b0, 8'h16);
    runOp("asr_b4_3", 8'hB4, 3'd3, 1'b1, 8'hF6);
    runOp("asr_74_3", 8'h74, 3'd3, 1'b1, 8'h0E);
    runOp("zero_a5", 8'hA5, 3'd0, 1'b1, 8'hA5);
    runOp("lsr_80_7", 8'h80, 3'd7, 1'b0, 8'h01);
    runOp("asr_80_7", 8'h80, 3'd7, 1'b1, 8'hFF);
    runOp("lsr_ff_1", 8'hFF, 3'd1, 1'b0, 8'h7F);

    // Start held high with new operands while busy must not disturb the running op.
    bus.start  = 1'b1;
    bus.data_1 = 8'h80;
    bus.data_2 = 3'd4;
    bus.arith  = 1'b0;
    @(posedge clk); #1;
    bus.data_1 = 8'h40;
    bus.data_2 = 3'd1;
    bus.arith  = 1'b0;
    checkOutput("hold_busy", bus.busy, 1'b1);
    cycles = 1;
    while (!bus.done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("hold_latency", cycles, 5);
    checkOutput("hold_first_out", bus.out, 8'h08);
    @(posedge clk); #1;
    checkOutput("hold_idle_busy", bus.busy, 1'b0);
    checkOutput("hold_idle_out", bus.out, 8'h08);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("hold_second_busy", bus.busy, 1'b1);
    checkOutput("hold_second_out_kept", bus.out, 8'h08);
    @(posedge clk); #1;
    checkOutput("hold_second_done", bus.done, 1'b1);
    checkOutput("hold_second_out", bus.out, 8'h20);
    @(posedge clk); #1;

    // Asynchronous reset two edges into a 6-bit shift aborts it immediately.
    bus.start  = 1'b1;
    bus.data_1 = 8'hC3;
    bus.data_2 = 3'd6;
    bus.arith  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    checkOutput("abort_out", bus.out, 8'h00);
    #2;
    reset = 1'b0;
    applyStimulus(8'hF0, 3'd4, 1'b0, cycles, res);
    checkOutput("after_reset_latency", cycles, 5);
    checkOutput("after_reset_out", res, 8'h0F);
    @(posedge clk); #1;
    checkOutput("after_reset_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
